// File: rtl/axi_lite_reg_slice.sv
// axi_lite_reg_slice: fully registered AXI4-Lite pipeline stage, one 2-entry skid buffer per channel.
// Define AXI_SLICE_DECERR_EN to terminate out-of-window addresses locally with DECERR.

module axi_lite_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_push,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             skid_full_next
);
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             out_fire;

  assign out_fire = out_valid & out_ready;

  // The skid entry only fills when a beat arrives while main is held by a stalled sink.
  always_comb begin
    skid_full_next = skid_valid;
    if (skid_valid) begin
      if (out_fire) skid_full_next = 1'b0;
    end else if (out_valid && !out_fire && in_push) begin
      skid_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      if (out_fire) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (!out_valid || out_fire) begin
      out_valid <= in_push;
      if (in_push) out_data <= in_data;
    end else if (in_push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

module axi_lite_reg_slice #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h43C0_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK      = 32'hFFFF_0000
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);
  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AW_WIDTH   = AXI_ADDR_WIDTH + 3;
  localparam int W_WIDTH    = AXI_DATA_WIDTH + STRB_WIDTH;
  localparam int R_WIDTH    = AXI_DATA_WIDTH + 2;

  if ((BASE_ADDR & ~ADDR_MASK) != '0) begin : g_base_check
    $error("BASE_ADDR has bits set outside ADDR_MASK");
  end

  logic aw_push, w_push, ar_push, b_push, r_push;
  logic aw_skid_next, w_skid_next, ar_skid_next, b_skid_next, r_skid_next;
  logic b_ready_q, r_ready_q;
  logic [1:0]                b_src_resp;
  logic [AXI_DATA_WIDTH-1:0] r_src_data;
  logic [1:0]                r_src_resp;
  logic [AW_WIDTH-1:0]       aw_out, ar_out;
  logic [W_WIDTH-1:0]        w_out;
  logic [R_WIDTH-1:0]        r_out;

`ifdef AXI_SLICE_DECERR_EN
  logic       wr_ready_q, rd_ready_q;
  logic       wr_fire, wr_in_win, wr_pend, wr_pend_next, b_local;
  logic       rd_fire, rd_in_win, rd_pend, rd_pend_next, r_local;
  logic [3:0] wr_cnt, wr_cnt_next, rd_cnt, rd_cnt_next;

  assign wr_fire    = s_axi_awvalid & s_axi_wvalid & wr_ready_q;
  assign wr_in_win  = (s_axi_awaddr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  assign aw_push    = wr_fire & wr_in_win;
  assign w_push     = aw_push;
  assign b_local    = wr_pend & (wr_cnt == 4'd0);
  assign b_push     = (b_local | m_axi_bvalid) & b_ready_q;
  assign b_src_resp = b_local ? 2'b11 : m_axi_bresp;

  assign rd_fire    = s_axi_arvalid & rd_ready_q;
  assign rd_in_win  = (s_axi_araddr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  assign ar_push    = rd_fire & rd_in_win;
  assign r_local    = rd_pend & (rd_cnt == 4'd0);
  assign r_push     = (r_local | m_axi_rvalid) & r_ready_q;
  assign r_src_data = r_local ? '0 : m_axi_rdata;
  assign r_src_resp = r_local ? 2'b11 : m_axi_rresp;

  assign s_axi_awready = wr_ready_q;
  assign s_axi_wready  = wr_ready_q;
  assign s_axi_arready = rd_ready_q;

  // A local error waits in *_pend until every forwarded transaction has returned its response.
  always_comb begin
    wr_cnt_next = wr_cnt;
    if (aw_push) wr_cnt_next = wr_cnt_next + 4'd1;
    if (m_axi_bvalid && b_ready_q && wr_cnt != 4'd0) wr_cnt_next = wr_cnt_next - 4'd1;
    rd_cnt_next = rd_cnt;
    if (ar_push) rd_cnt_next = rd_cnt_next + 4'd1;
    if (m_axi_rvalid && r_ready_q && rd_cnt != 4'd0) rd_cnt_next = rd_cnt_next - 4'd1;
    wr_pend_next = wr_pend;
    if (wr_pend) begin
      if (b_local && b_ready_q) wr_pend_next = 1'b0;
    end else if (wr_fire && !wr_in_win) begin
      wr_pend_next = 1'b1;
    end
    rd_pend_next = rd_pend;
    if (rd_pend) begin
      if (r_local && r_ready_q) rd_pend_next = 1'b0;
    end else if (rd_fire && !rd_in_win) begin
      rd_pend_next = 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ready_q <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_pend    <= 1'b0;
      rd_pend    <= 1'b0;
      wr_cnt     <= 4'd0;
      rd_cnt     <= 4'd0;
    end else begin
      wr_ready_q <= !aw_skid_next && !w_skid_next && !wr_pend_next && (wr_cnt_next != 4'd15);
      rd_ready_q <= !ar_skid_next && !rd_pend_next && (rd_cnt_next != 4'd15);
      wr_pend    <= wr_pend_next;
      rd_pend    <= rd_pend_next;
      wr_cnt     <= wr_cnt_next;
      rd_cnt     <= rd_cnt_next;
    end
  end
`else
  logic aw_ready_q, w_ready_q, ar_ready_q;

  assign aw_push    = s_axi_awvalid & aw_ready_q;
  assign w_push     = s_axi_wvalid & w_ready_q;
  assign ar_push    = s_axi_arvalid & ar_ready_q;
  assign b_push     = m_axi_bvalid & b_ready_q;
  assign r_push     = m_axi_rvalid & r_ready_q;
  assign b_src_resp = m_axi_bresp;
  assign r_src_data = m_axi_rdata;
  assign r_src_resp = m_axi_rresp;

  assign s_axi_awready = aw_ready_q;
  assign s_axi_wready  = w_ready_q;
  assign s_axi_arready = ar_ready_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      ar_ready_q <= 1'b0;
    end else begin
      aw_ready_q <= !aw_skid_next;
      w_ready_q  <= !w_skid_next;
      ar_ready_q <= !ar_skid_next;
    end
  end
`endif

  // Ready flops stay low through reset and rise on the first edge after release.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      b_ready_q <= 1'b0;
      r_ready_q <= 1'b0;
    end else begin
      b_ready_q <= !b_skid_next;
      r_ready_q <= !r_skid_next;
    end
  end

  assign m_axi_bready = b_ready_q;
  assign m_axi_rready = r_ready_q;

  axi_lite_skid #(.WIDTH(AW_WIDTH)) u_aw (
    .clk(axi_aclk), .rst_n(axi_aresetn), .in_push(aw_push),
    .in_data({s_axi_awprot, s_axi_awaddr}),
    .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data(aw_out),
    .skid_full_next(aw_skid_next)
  );
  assign {m_axi_awprot, m_axi_awaddr} = aw_out;

  axi_lite_skid #(.WIDTH(W_WIDTH)) u_w (
    .clk(axi_aclk), .rst_n(axi_aresetn), .in_push(w_push),
    .in_data({s_axi_wstrb, s_axi_wdata}),
    .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out),
    .skid_full_next(w_skid_next)
  );
  assign {m_axi_wstrb, m_axi_wdata} = w_out;

  axi_lite_skid #(.WIDTH(2)) u_b (
    .clk(axi_aclk), .rst_n(axi_aresetn), .in_push(b_push),
    .in_data(b_src_resp),
    .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(s_axi_bresp),
    .skid_full_next(b_skid_next)
  );

  axi_lite_skid #(.WIDTH(AW_WIDTH)) u_ar (
    .clk(axi_aclk), .rst_n(axi_aresetn), .in_push(ar_push),
    .in_data({s_axi_arprot, s_axi_araddr}),
    .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data(ar_out),
    .skid_full_next(ar_skid_next)
  );
  assign {m_axi_arprot, m_axi_araddr} = ar_out;

  axi_lite_skid #(.WIDTH(R_WIDTH)) u_r (
    .clk(axi_aclk), .rst_n(axi_aresetn), .in_push(r_push),
    .in_data({r_src_resp, r_src_data}),
    .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out),
    .skid_full_next(r_skid_next)
  );
  assign {s_axi_rresp, s_axi_rdata} = r_out;
endmodule

// File: tb/tb_axi_lite_reg_slice.sv
// Directed self-checking bench for axi_lite_reg_slice: vector table plus multi-cycle corner sequences.
// Sequences guarded by AXI_SLICE_DECERR_EN exercise the local DECERR path.

module tb_axi_lite_reg_slice;
  logic        clk = 1'b0;
  logic        axi_aresetn;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_reg_slice dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  slv_resp;
    logic [31:0] slv_rdata;
    logic [31:0] exp_addr;
    logic [2:0]  exp_prot;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bresp = '0; m_axi_bvalid = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;
  endtask

  task automatic doReset();
    axi_aresetn = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    axi_aresetn = 1'b1;
    tick();
  endtask

  // One full transaction through the slice with every sink ready.
  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.is_write) begin
      s_axi_awaddr = v.addr; s_axi_awprot = v.prot; s_axi_awvalid = 1'b1;
      s_axi_wdata = v.data; s_axi_wstrb = v.strb; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      checkOutput($sformatf("v%0d_m_awvalid", idx), m_axi_awvalid, 1);
      checkOutput($sformatf("v%0d_m_awaddr", idx), m_axi_awaddr, v.exp_addr);
      checkOutput($sformatf("v%0d_m_awprot", idx), m_axi_awprot, v.exp_prot);
      checkOutput($sformatf("v%0d_m_wvalid", idx), m_axi_wvalid, 1);
      checkOutput($sformatf("v%0d_m_wdata", idx), m_axi_wdata, v.exp_data);
      checkOutput($sformatf("v%0d_m_wstrb", idx), m_axi_wstrb, v.exp_strb);
      tick();
      checkOutput($sformatf("v%0d_m_awvalid_drop", idx), m_axi_awvalid, 0);
      m_axi_bvalid = 1'b1; m_axi_bresp = v.slv_resp;
      tick();
      m_axi_bvalid = 1'b0;
      checkOutput($sformatf("v%0d_s_bvalid", idx), s_axi_bvalid, 1);
      checkOutput($sformatf("v%0d_s_bresp", idx), s_axi_bresp, v.exp_resp);
      tick();
      checkOutput($sformatf("v%0d_s_bvalid_drop", idx), s_axi_bvalid, 0);
    end else begin
      s_axi_araddr = v.addr; s_axi_arprot = v.prot; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      checkOutput($sformatf("v%0d_m_arvalid", idx), m_axi_arvalid, 1);
      checkOutput($sformatf("v%0d_m_araddr", idx), m_axi_araddr, v.exp_addr);
      checkOutput($sformatf("v%0d_m_arprot", idx), m_axi_arprot, v.exp_prot);
      tick();
      checkOutput($sformatf("v%0d_m_arvalid_drop", idx), m_axi_arvalid, 0);
      m_axi_rvalid = 1'b1; m_axi_rdata = v.slv_rdata; m_axi_rresp = v.slv_resp;
      tick();
      m_axi_rvalid = 1'b0;
      checkOutput($sformatf("v%0d_s_rvalid", idx), s_axi_rvalid, 1);
      checkOutput($sformatf("v%0d_s_rdata", idx), s_axi_rdata, v.exp_rdata);
      checkOutput($sformatf("v%0d_s_rresp", idx), s_axi_rresp, v.exp_resp);
      tick();
      checkOutput($sformatf("v%0d_s_rvalid_drop", idx), s_axi_rvalid, 0);
    end
  endtask

  // Eight back-to-back reads with the downstream stalled during cycles 3-5.
  task automatic arBurst();
    logic [31:0] addrs [8];
    logic [31:0] seen [16];
    int sent = 0;
    int nseen = 0;
    for (int i = 0; i < 8; i++) addrs[i] = 32'h43C0_0100 + 32'(i * 4);
    doReset();
    for (int c = 0; c < 16; c++) begin
      s_axi_arvalid = (sent < 8);
      if (sent < 8) s_axi_araddr = addrs[sent];
      m_axi_arready = !(c >= 3 && c <= 5);
      checkOutput($sformatf("ar_ready_c%0d", c), s_axi_arready, (c >= 4 && c <= 6) ? 0 : 1);
      if (c == 4 || c == 5) begin
        checkOutput($sformatf("ar_hold_valid_c%0d", c), m_axi_arvalid, 1);
        checkOutput($sformatf("ar_hold_addr_c%0d", c), m_axi_araddr, addrs[2]);
      end
      @(negedge clk);
      if (s_axi_arvalid && s_axi_arready) sent++;
      if (m_axi_arvalid && m_axi_arready) begin
        if (nseen < 16) seen[nseen] = m_axi_araddr;
        nseen++;
      end
      tick();
    end
    s_axi_arvalid = 1'b0;
    checkOutput("ar_sent_count", sent, 8);
    checkOutput("ar_fwd_count", nseen, 8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("ar_order_%0d", i), seen[i], addrs[i]);
  endtask

  // R beats offered every cycle while the upstream master toggles rready 1010.
  task automatic rBurst();
    logic [31:0] beats [4];
    int fed = 0;
    int got = 0;
    bit prev_stall = 1'b0;
    beats[0] = 32'h1111_0000; beats[1] = 32'h2222_0001;
    beats[2] = 32'h3333_0002; beats[3] = 32'h4444_0003;
    doReset();
    for (int c = 0; c < 20; c++) begin
      m_axi_rvalid = (fed < 4);
      if (fed < 4) m_axi_rdata = beats[fed];
      m_axi_rresp = 2'b00;
      s_axi_rready = (c % 2 == 0);
      if (prev_stall) checkOutput($sformatf("r_hold_valid_c%0d", c), s_axi_rvalid, 1);
      if (s_axi_rvalid) begin
        if (got < 4) checkOutput($sformatf("r_data_c%0d", c), s_axi_rdata, beats[got]);
        else checkOutput($sformatf("r_extra_c%0d", c), s_axi_rvalid, 0);
      end
      @(negedge clk);
      prev_stall = s_axi_rvalid && !s_axi_rready;
      if (s_axi_rvalid && s_axi_rready) got++;
      if (m_axi_rvalid && m_axi_rready) fed++;
      tick();
    end
    m_axi_rvalid = 1'b0;
    s_axi_rready = 1'b1;
    checkOutput("r_beats_delivered", got, 4);
    checkOutput("r_beats_taken", fed, 4);
  endtask

`ifdef AXI_SLICE_DECERR_EN
  task automatic decerrRead();
    doReset();
    s_axi_araddr = 32'h4000_0000; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    checkOutput("de_rd_m_arvalid_c1", m_axi_arvalid, 0);
    checkOutput("de_rd_s_rvalid_c1", s_axi_rvalid, 0);
    checkOutput("de_rd_s_arready_c1", s_axi_arready, 0);
    tick();
    checkOutput("de_rd_s_rvalid", s_axi_rvalid, 1);
    checkOutput("de_rd_s_rresp", s_axi_rresp, 2'b11);
    checkOutput("de_rd_s_rdata", s_axi_rdata, 0);
    checkOutput("de_rd_m_arvalid_c2", m_axi_arvalid, 0);
    tick();
    checkOutput("de_rd_s_rvalid_drop", s_axi_rvalid, 0);
    checkOutput("de_rd_s_arready_back", s_axi_arready, 1);
  endtask

  task automatic decerrWriteOrder();
    doReset();
    s_axi_awaddr = 32'h43C0_0000; s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awaddr = 32'h5000_0000; s_axi_wdata = 32'h6;
    checkOutput("de_wr_fwd_awvalid", m_axi_awvalid, 1);
    checkOutput("de_wr_fwd_awaddr", m_axi_awaddr, 32'h43C0_0000);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("de_wr_wait_bvalid_%0d", c), s_axi_bvalid, 0);
      checkOutput($sformatf("de_wr_wait_awvalid_%0d", c), m_axi_awvalid, 0);
      checkOutput($sformatf("de_wr_wait_wvalid_%0d", c), m_axi_wvalid, 0);
      checkOutput($sformatf("de_wr_wait_awready_%0d", c), s_axi_awready, 0);
      tick();
    end
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    tick();
    m_axi_bvalid = 1'b0;
    checkOutput("de_wr_first_bvalid", s_axi_bvalid, 1);
    checkOutput("de_wr_first_bresp", s_axi_bresp, 2'b00);
    tick();
    checkOutput("de_wr_local_bvalid", s_axi_bvalid, 1);
    checkOutput("de_wr_local_bresp", s_axi_bresp, 2'b11);
    tick();
    checkOutput("de_wr_bvalid_drop", s_axi_bvalid, 0);
    checkOutput("de_wr_awready_back", s_axi_awready, 1);
  endtask
`else
  task automatic forwardAnyRead();
    doReset();
    s_axi_araddr = 32'h4000_0000; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    checkOutput("fw_rd_m_arvalid", m_axi_arvalid, 1);
    checkOutput("fw_rd_m_araddr", m_axi_araddr, 32'h4000_0000);
    tick();
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_0011; m_axi_rresp = 2'b00;
    tick();
    m_axi_rvalid = 1'b0;
    checkOutput("fw_rd_s_rvalid", s_axi_rvalid, 1);
    checkOutput("fw_rd_s_rdata", s_axi_rdata, 32'h0000_0011);
    checkOutput("fw_rd_s_rresp", s_axi_rresp, 2'b00);
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h43C0_0000, 3'd0, 32'h0000_000A, 4'hF, 2'b00, 32'h0,
                32'h43C0_0000, 3'd0, 32'h0000_000A, 4'hF, 2'b00, 32'h0};
    vecs[1] = '{1'b1, 32'h43C0_0004, 3'd2, 32'hDEAD_BEEF, 4'h3, 2'b10, 32'h0,
                32'h43C0_0004, 3'd2, 32'hDEAD_BEEF, 4'h3, 2'b10, 32'h0};
    vecs[2] = '{1'b1, 32'h43C0_FFFC, 3'd7, 32'h1234_5678, 4'h8, 2'b00, 32'h0,
                32'h43C0_FFFC, 3'd7, 32'h1234_5678, 4'h8, 2'b00, 32'h0};
    vecs[3] = '{1'b0, 32'h43C0_0000, 3'd0, 32'h0, 4'h0, 2'b00, 32'hA5A5_A5A5,
                32'h43C0_0000, 3'd0, 32'h0, 4'h0, 2'b00, 32'hA5A5_A5A5};
    vecs[4] = '{1'b0, 32'h43C0_0010, 3'd1, 32'h0, 4'h0, 2'b10, 32'h0000_0001,
                32'h43C0_0010, 3'd1, 32'h0, 4'h0, 2'b10, 32'h0000_0001};
    vecs[5] = '{1'b0, 32'h43C0_FFFC, 3'd5, 32'h0, 4'h0, 2'b00, 32'hFFFF_FFFF,
                32'h43C0_FFFC, 3'd5, 32'h0, 4'h0, 2'b00, 32'hFFFF_FFFF};

    axi_aresetn = 1'b0;
    clearInputs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_awready", s_axi_awready, 0);
    checkOutput("rst_s_arready", s_axi_arready, 0);
    checkOutput("rst_m_bready", m_axi_bready, 0);
    checkOutput("rst_m_awvalid", m_axi_awvalid, 0);
    checkOutput("rst_s_rvalid", s_axi_rvalid, 0);
    axi_aresetn = 1'b1;
    #1;
    checkOutput("rel_s_wready_pre_edge", s_axi_wready, 0);
    tick();
    checkOutput("rel_s_awready", s_axi_awready, 1);
    checkOutput("rel_s_wready", s_axi_wready, 1);
    checkOutput("rel_s_arready", s_axi_arready, 1);
    checkOutput("rel_m_bready", m_axi_bready, 1);
    checkOutput("rel_m_rready", m_axi_rready, 1);
    checkOutput("rel_m_wvalid", m_axi_wvalid, 0);
    checkOutput("rel_m_arvalid", m_axi_arvalid, 0);
    checkOutput("rel_s_bvalid", s_axi_bvalid, 0);
    checkOutput("rel_m_awaddr", m_axi_awaddr, 0);
    checkOutput("rel_s_rdata", s_axi_rdata, 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    arBurst();
    rBurst();
`ifdef AXI_SLICE_DECERR_EN
    decerrRead();
    decerrWriteOrder();
`else
    forwardAnyRead();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_slice.md
Name: axi_lite_reg_slice

Overview:
- Registered AXI4-Lite pipeline stage inserted between the JTAG-AXI bridge master port and downstream slaves (LED register, future peripherals).
- Breaks all combinational valid/ready paths on the five channels for timing closure.
- Keeps full throughput: one transfer per cycle per channel.
- Optionally terminates out-of-window addresses locally with DECERR.

Parameters:
- AXI_ADDR_WIDTH, 32, address width, both sides.
- AXI_DATA_WIDTH, 32, data width; strobe width = AXI_DATA_WIDTH/8.
- BASE_ADDR, 32'h43C00000, window base; used only with the optional feature.
- ADDR_MASK, 32'hFFFF0000, window mask; used only with the optional feature.

Ports:
- axi_aclk  in  1  clock for both sides.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- s_axi_awaddr/awprot/awvalid  in  AXI_ADDR_WIDTH/3/1  upstream write address; s_axi_awready out 1.
- s_axi_wdata/wstrb/wvalid  in  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1  upstream write data; s_axi_wready out 1.
- s_axi_bresp/bvalid  out  2/1  upstream write response; s_axi_bready in 1.
- s_axi_araddr/arprot/arvalid  in  AXI_ADDR_WIDTH/3/1  upstream read address; s_axi_arready out 1.
- s_axi_rdata/rresp/rvalid  out  AXI_DATA_WIDTH/2/1  upstream read data; s_axi_rready in 1.
- m_axi_awaddr/awprot/awvalid  out  AXI_ADDR_WIDTH/3/1  downstream write address; m_axi_awready in 1.
- m_axi_wdata/wstrb/wvalid  out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1  downstream write data; m_axi_wready in 1.
- m_axi_bresp/bvalid  in  2/1  downstream write response; m_axi_bready out 1.
- m_axi_araddr/arprot/arvalid  out  AXI_ADDR_WIDTH/3/1  downstream read address; m_axi_arready in 1.
- m_axi_rdata/rresp/rvalid  in  AXI_DATA_WIDTH/2/1  downstream read data; m_axi_rready out 1.

Behaviour:
- Clock and reset: one clock, axi_aclk. Reset is asynchronous, active-low, on axi_aresetn; all state is cleared immediately on assertion.
- Channel structure: each channel is an independent 2-entry skid buffer (main register plus skid register). Forward direction: AW, W, AR flow s->m; B, R flow m->s.
- Output registers: every output valid, ready and payload is driven directly from a flop.
- Reset values:
  - All *valid outputs are 0.
  - All *ready outputs are 0 during reset and go to 1 on the first clock edge after deassertion.
  - Payload outputs are 0.
- Latency: 1 cycle input-accept to output-valid on every channel.
- Throughput: 1 beat/cycle when the sink is always ready.
- Handshake rules:
  - Transfer occurs when valid and ready are both high at the clock edge.
  - Output valid, once high, stays high with stable payload until accepted.
  - Input ready = NOT skid_full. Ready deasserts one cycle after the sink stalls with main full; the beat in flight is captured in skid.
- Sink stall with skid full: no input accepted. On the next sink accept, the skid entry moves to main and ready rises the same edge.
- Simultaneous input accept and output accept with main full, skid empty: main loads the new beat; no skid use.
- Ordering: strict in-order per channel. No reordering between AW and W; each is forwarded independently.
- Reset mid-transaction: all buffered beats are discarded with no response generated. The upstream master must also be in reset (shared axi_aresetn).

Optional Feature:
- Macro: AXI_SLICE_DECERR_EN.
- Defined:
  - Address match rule: in-window when (addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
  - Write acceptance: AW and W are accepted only jointly, in the same cycle.
  - Out-of-window write: AW and W are not forwarded; a local B with bresp=2'b11 is issued.
  - Out-of-window read: a local R with rresp=2'b11 and rdata=0 is issued.
  - Ordering against forwarded traffic: a 4-bit outstanding counter per direction tracks forwarded transactions. A local error is issued only when the counter is 0; otherwise input accept stalls. Counter at 15 also stalls.
  - Error latency: 2 cycles from accept.
- Undefined: pure pipeline, no decode. BASE_ADDR and ADDR_MASK are ignored; all transactions are forwarded.

Test Plan:
- Reset release, m_*ready=1 -> all s_*ready=1 and all valids=0 one cycle after axi_aresetn rises.
- Write 0x43C00000/0x0000000A, m_axi_awready=m_axi_wready=1 -> m_axi_awvalid/wvalid high 1 cycle later with same payload; bresp 2'b00 returned 1 cycle after m_axi_bvalid.
- 8 back-to-back reads, m_axi_arready held 0 for cycles 3-5 -> s_axi_arready falls 1 cycle after stall; all 8 addresses appear on m_axi_araddr in order, none lost or duplicated.
- R channel: m_axi_rvalid every cycle, s_axi_rready toggling 1010 -> rdata stable while stalled; 4 beats delivered in order.
- AXI_SLICE_DECERR_EN: read 0x40000000 -> no m_axi_arvalid; s_axi_rresp=2'b11, rdata=0 two cycles later.
- AXI_SLICE_DECERR_EN: in-window write outstanding, then out-of-window write -> local DECERR B issued only after the forwarded B returns.
